// File: rtl/axi_lite_ram_slave_pkg.sv
// Shared definitions for the AXI4-Lite data-RAM responder: response codes,
// controller states and the address-window decode helper.
package axi_lite_ram_slave_pkg;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_RESP,
    ST_WR_DATA,
    ST_WR_RESP
  } state_e;

  // Widened to 33 bits so a window ending at 4 GiB does not wrap.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/axi_lite_ram_slave_array.sv
// DEPTH x 64-bit single-port RAM with byte-enabled synchronous write and
// registered read data (read-before-write on the shared address port).
module axi_ram_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite responder for the data RAM: one transaction in flight, reads win
// over writes, programmable read latency, SLVERR outside the decoded window.
module axi_lite_ram_slave
  import axi_lite_ram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(8 * DEPTH);
  localparam logic [3:0]  LAT_INIT = 4'(READ_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        hit_q, hit_d;
  logic        arready_q, arready_d, awready_q, awready_d, wready_q, wready_d;
  logic        rvalid_q, rvalid_d, bvalid_q, bvalid_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d, bresp_q, bresp_d;

  logic          ar_hs, aw_hs, ram_we;
  logic [31:0]   ram_byte_addr;
  logic [AW-1:0] ram_addr;
  logic [63:0]   ram_rdata;

  assign awready = awready_q & ~arvalid;
  assign ar_hs   = (state_q == ST_IDLE) && arvalid && arready_q;
  assign aw_hs   = (state_q == ST_IDLE) && awvalid && awready;

  // The RAM is addressed from araddr while idle so its registered read lines up
  // with the AR handshake edge, which makes READ_LAT=1 reachable.
  assign ram_byte_addr = (state_q == ST_IDLE) ? araddr : addr_q;
  assign ram_addr      = AW'((ram_byte_addr - BASE_ADDR) >> 3);
  assign ram_we        = (state_q == ST_WR_DATA) && wvalid && wready_q && hit_q;

  axi_ram_array #(.DEPTH(DEPTH)) u_array (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .be   (wstrb),
    .wdata(wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    hit_d    = hit_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          addr_d  = araddr;
          hit_d   = addr_hit(araddr, BASE_ADDR, SPAN);
          cnt_d   = LAT_INIT;
          state_d = ST_RD_WAIT;
        end else if (aw_hs) begin
          addr_d  = awaddr;
          hit_d   = addr_hit(awaddr, BASE_ADDR, SPAN);
          state_d = ST_WR_DATA;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          rvalid_d = 1'b1;
          rdata_d  = hit_q ? ram_rdata : '0;
          rresp_d  = hit_q ? AXI_OKAY : AXI_SLVERR;
          state_d  = ST_RD_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RD_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        if (wvalid && wready_q) begin
          bvalid_d = 1'b1;
          bresp_d  = hit_q ? AXI_OKAY : AXI_SLVERR;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    arready_d = (state_d == ST_IDLE);
    awready_d = (state_d == ST_IDLE);
    wready_d  = (state_d == ST_WR_DATA);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      hit_q     <= 1'b0;
      arready_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AXI_OKAY;
      bresp_q   <= AXI_OKAY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      hit_q     <= hit_d;
      arready_q <= arready_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      rvalid_q  <= rvalid_d;
      bvalid_q  <= bvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
    end
  end

  assign arready = arready_q;
  assign wready  = wready_q;
  assign rvalid  = rvalid_q;
  assign bvalid  = bvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Self-checking bench for axi_lite_ram_slave: directed vector table, corner
// sequences (contention, back-pressure, reset) and random traffic vs a word model.
module tb_axi_lite_ram_slave;

  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam int unsigned DEPTH    = 1024;
  localparam int unsigned RL       = 3;
  localparam int unsigned LIMIT    = 200;
  localparam logic [31:0] END_ADDR = BASE + 32'(8 * DEPTH);

  logic        clk, rst;
  logic [31:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [63:0] model [int unsigned];

  axi_lite_ram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: no handshake within %0d cycles", name, LIMIT);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a sparse word array addressed by (addr-BASE)/8.
  function automatic bit ref_hit(input logic [31:0] a);
    logic [63:0] aa;
    aa = {32'h0, a};
    return (aa >= 64'(BASE)) && (aa < 64'(BASE) + 64'(8 * DEPTH));
  endfunction

  function automatic int unsigned ref_idx(input logic [31:0] a);
    return (a - BASE) / 8;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] mask;
    if (!ref_hit(a)) return;
    mask = '0;
    for (int i = 0; i < 8; i++) if (s[i]) mask = mask | (64'hFF << (8 * i));
    model[ref_idx(a)] = (model[ref_idx(a)] & ~mask) | (d & mask);
  endtask

  function automatic logic [63:0] ref_rdata(input logic [31:0] a);
    if (!ref_hit(a)) return '0;
    return model[ref_idx(a)];
  endfunction

  function automatic logic [1:0] ref_resp(input logic [31:0] a);
    return ref_hit(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           output logic [1:0] resp);
    int unsigned n;
    resp = 'x;
    awaddr = a; awvalid = 1'b1; n = 0;
    while (!awready && n < LIMIT) begin step(); n++; end
    if (!awready) begin expired("aw handshake"); awvalid = 1'b0; return; end
    step(); awvalid = 1'b0;
    wdata = d; wstrb = s; wvalid = 1'b1; n = 0;
    while (!wready && n < LIMIT) begin step(); n++; end
    if (!wready) begin expired("w handshake"); wvalid = 1'b0; return; end
    step(); wvalid = 1'b0; bready = 1'b1; n = 0;
    while (!bvalid && n < LIMIT) begin step(); n++; end
    if (!bvalid) begin expired("b handshake"); bready = 1'b0; return; end
    resp = bresp;
    step(); bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp,
                          output int unsigned lat);
    int unsigned n;
    d = 'x; resp = 'x; lat = 0;
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < LIMIT) begin step(); n++; end
    if (!arready) begin expired("ar handshake"); arvalid = 1'b0; return; end
    step(); arvalid = 1'b0;
    while (!rvalid && lat < LIMIT) begin step(); lat++; end
    if (!rvalid) begin expired("r handshake"); return; end
    d = rdata; resp = rresp;
    rready = 1'b1;
    step(); rready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  resp;
    logic [63:0] rdata;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [63:0] d;
    logic [1:0]  r;
    int unsigned lat, n;
    int unsigned pool [6];
    logic [31:0] a;

    rst = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;

    tbl[0]  = '{1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 2'b00, 64'h0};
    tbl[1]  = '{1'b0, 32'h8000_0010, 64'h0, 8'h00, 2'b00, 64'h1122_3344_5566_7788};
    tbl[2]  = '{1'b1, 32'h8000_0010, 64'hFFFF_FFFF_AAAA_AAAA, 8'h0F, 2'b00, 64'h0};
    tbl[3]  = '{1'b0, 32'h8000_0010, 64'h0, 8'h00, 2'b00, 64'h1122_3344_AAAA_AAAA};
    tbl[4]  = '{1'b0, 32'h7FFF_FFF8, 64'h0, 8'h00, 2'b10, 64'h0};
    tbl[5]  = '{1'b1, 32'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00, 64'h0};
    tbl[6]  = '{1'b1, END_ADDR,      64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 2'b10, 64'h0};
    tbl[7]  = '{1'b0, 32'h8000_0000, 64'h0, 8'h00, 2'b00, 64'h0123_4567_89AB_CDEF};
    tbl[8]  = '{1'b1, 32'h8000_0010, 64'h0, 8'h00, 2'b00, 64'h0};
    tbl[9]  = '{1'b0, 32'h8000_0017, 64'h0, 8'h00, 2'b00, 64'h1122_3344_AAAA_AAAA};
    tbl[10] = '{1'b1, 32'h8000_1FF8, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 2'b00, 64'h0};
    tbl[11] = '{1'b0, 32'h8000_1FFF, 64'h0, 8'h00, 2'b00, 64'hA5A5_5A5A_0F0F_F0F0};
    tbl[12] = '{1'b0, END_ADDR,      64'h0, 8'h00, 2'b10, 64'h0};
    tbl[13] = '{1'b1, 32'h7FFF_FFF8, 64'h1234_1234_1234_1234, 8'hFF, 2'b10, 64'h0};
    tbl[14] = '{1'b0, 32'h8000_1FF8, 64'h0, 8'h00, 2'b00, 64'hA5A5_5A5A_0F0F_F0F0};

    // Reset state.
    step(); step();
    check("reset flags", 64'({arready, awready, wready, bvalid, rvalid}), 64'h0);
    check("reset resp", 64'({rresp, bresp}), 64'h0);
    check("reset rdata", rdata, 64'h0);
    rst = 1'b1;
    step();

    // Directed vector table.
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
        check($sformatf("tbl%0d bresp", i), 64'(r), 64'(tbl[i].resp));
        ref_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
      end else begin
        axi_read(tbl[i].addr, d, r, lat);
        check($sformatf("tbl%0d rdata", i), d, tbl[i].rdata);
        check($sformatf("tbl%0d rresp", i), 64'(r), 64'(tbl[i].resp));
        check($sformatf("tbl%0d latency", i), 64'(lat), 64'(RL));
      end
    end

    // AR and AW raised together: read wins, AW waits, write follows.
    a = BASE + 32'h40;
    axi_write(a, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, r);
    ref_write(a, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF);
    araddr = a; awaddr = a; arvalid = 1'b1; awvalid = 1'b1;
    wdata = 64'h600D_600D_600D_600D; wstrb = 8'hFF;
    #1;
    check("simul awready gated", 64'(awready), 64'h0);
    n = 0;
    while (!arready && n < LIMIT) begin step(); n++; end
    check("simul arready", 64'(arready), 64'h1);
    check("simul awready while arvalid", 64'(awready), 64'h0);
    step(); arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < LIMIT) begin
      check("simul aw held off", 64'(awready), 64'h0);
      step(); lat++;
    end
    check("simul latency", 64'(lat), 64'(RL));
    check("simul rdata old", rdata, ref_rdata(a));
    rready = 1'b1; step(); rready = 1'b0;
    n = 0;
    while (!awready && n < LIMIT) begin step(); n++; end
    if (!awready) expired("simul aw");
    step(); awvalid = 1'b0; wvalid = 1'b1; n = 0;
    while (!wready && n < LIMIT) begin step(); n++; end
    step(); wvalid = 1'b0; bready = 1'b1; n = 0;
    while (!bvalid && n < LIMIT) begin step(); n++; end
    check("simul bresp", 64'({bvalid, bresp}), 64'({1'b1, 2'b00}));
    step(); bready = 1'b0;
    ref_write(a, 64'h600D_600D_600D_600D, 8'hFF);
    axi_read(a, d, r, lat);
    check("simul rdata new", d, ref_rdata(a));

    // rready held low: response stays put and no new AR is accepted.
    araddr = 32'h8000_0010; arvalid = 1'b1; n = 0;
    while (!arready && n < LIMIT) begin step(); n++; end
    step(); arvalid = 1'b0; lat = 0;
    while (!rvalid && lat < LIMIT) begin step(); lat++; end
    check("hold latency", 64'(lat), 64'(RL));
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold%0d rvalid", i), 64'(rvalid), 64'h1);
      check($sformatf("hold%0d rdata", i), rdata, ref_rdata(32'h8000_0010));
      check($sformatf("hold%0d rresp", i), 64'(rresp), 64'h0);
      check($sformatf("hold%0d arready", i), 64'(arready), 64'h0);
    end
    rready = 1'b1; step(); rready = 1'b0;
    check("hold released", 64'(rvalid), 64'h0);

    // Reset in the middle of a read.
    araddr = 32'h8000_0000; arvalid = 1'b1; n = 0;
    while (!arready && n < LIMIT) begin step(); n++; end
    step(); arvalid = 1'b0;
    rst = 1'b0; #1;
    check("rst mid-read flags", 64'({arready, awready, wready, bvalid, rvalid}), 64'h0);
    check("rst mid-read rdata", rdata, 64'h0);
    step(); rst = 1'b1; step();

    // Reset while write data is presented but not yet clocked: nothing committed.
    a = BASE + 32'h80;
    axi_write(a, 64'h1111_2222_3333_4444, 8'hFF, r);
    ref_write(a, 64'h1111_2222_3333_4444, 8'hFF);
    awaddr = a; awvalid = 1'b1; n = 0;
    while (!awready && n < LIMIT) begin step(); n++; end
    step(); awvalid = 1'b0; wdata = 64'hFFFF_FFFF_FFFF_FFFF; wstrb = 8'hFF; wvalid = 1'b1;
    #2 rst = 1'b0;
    step(); wvalid = 1'b0; rst = 1'b1; step();
    axi_read(a, d, r, lat);
    check("rst before w kept old", d, ref_rdata(a));

    // Reset after the write was clocked: the write survives.
    awaddr = a; awvalid = 1'b1; n = 0;
    while (!awready && n < LIMIT) begin step(); n++; end
    step(); awvalid = 1'b0; wdata = 64'h5555_6666_7777_8888; wstrb = 8'hF0; wvalid = 1'b1; n = 0;
    while (!wready && n < LIMIT) begin step(); n++; end
    step(); wvalid = 1'b0;
    ref_write(a, 64'h5555_6666_7777_8888, 8'hF0);
    rst = 1'b0; #1;
    check("rst mid-resp bvalid", 64'(bvalid), 64'h0);
    step(); rst = 1'b1; step();
    axi_read(a, d, r, lat);
    check("rst after w kept new", d, ref_rdata(a));

    // Random traffic over a small pool of words plus out-of-window addresses.
    foreach (pool[i]) begin
      pool[i] = $urandom_range(DEPTH - 1, 0);
      a = BASE + 32'(pool[i] * 8);
      d = {$urandom, $urandom};
      axi_write(a, d, 8'hFF, r);
      ref_write(a, d, 8'hFF);
    end
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(9, 0))
        0:       a = 32'($urandom_range(32'h7FFF_FFFF, 0));
        1:       a = END_ADDR + 32'($urandom_range(32'h7FFF_0000, 0));
        default: a = BASE + 32'(pool[$urandom_range(5, 0)] * 8) + 32'($urandom_range(7, 0));
      endcase
      if ($urandom_range(1, 0) == 1) begin
        d = {$urandom, $urandom};
        wstrb = 8'($urandom);
        axi_write(a, d, wstrb, r);
        check($sformatf("rnd%0d bresp @%h", k, a), 64'(r), 64'(ref_resp(a)));
        ref_write(a, d, wstrb);
      end else begin
        axi_read(a, d, r, lat);
        check($sformatf("rnd%0d rdata @%h", k, a), d, ref_rdata(a));
        check($sformatf("rnd%0d rresp @%h", k, a), 64'(r), 64'(ref_resp(a)));
        check($sformatf("rnd%0d latency", k), 64'(lat), 64'(RL));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
